// File: rtl/pack6_ctrl.sv
// pack6_ctrl: packs up to six inwidth-bit lanes into one output word.
// A group closes after six lanes or on in_last, then is held until consumed.
module pack6_ctrl #(
  parameter int inwidth = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [inwidth-1:0]     in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [6*inwidth-1:0]   out_data,
  output logic [2:0]             out_count,
  output logic                   out_valid,
  input  logic                   out_ready
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  state_e                 state_q;
  logic [2:0]             lane_idx_q;
  logic [6*inwidth-1:0]   pack_q;
  logic [2:0]             out_count_q;
  logic                   out_valid_q;
  logic                   accept;
  logic                   consume;

  // In HOLD a new lane may only enter when the held word leaves.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid_q && out_ready;

  assign out_data  = pack_q;
  assign out_count = out_count_q;
  assign out_valid = out_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= COLLECT;
      lane_idx_q  <= 3'd0;
      pack_q      <= '0;
      out_count_q <= 3'd0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (accept) begin
            for (int k = 0; k < 6; k++) begin
              if (lane_idx_q == 3'(k)) begin
                pack_q[k*inwidth +: inwidth] <= in_data;
              end
            end
            if (lane_idx_q == 3'd5 || in_last) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              out_count_q <= lane_idx_q + 3'd1;
            end else begin
              lane_idx_q  <= lane_idx_q + 3'd1;
            end
          end
        end
        HOLD: begin
          if (consume && accept) begin
            pack_q <= {{(5*inwidth){1'b0}}, in_data};
            if (in_last) begin
              out_count_q <= 3'd1;
            end else begin
              lane_idx_q  <= 3'd1;
              state_q     <= COLLECT;
              out_valid_q <= 1'b0;
            end
          end else if (consume) begin
            pack_q      <= '0;
            lane_idx_q  <= 3'd0;
            state_q     <= COLLECT;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= COLLECT;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
